// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA bus initiator.
package oam_dma_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned DMA_LEN = 256;

    localparam logic [ADDR_W-1:0] DEF_TRIGGER_ADDR = 16'h4014;
    localparam logic [ADDR_W-1:0] DEF_DEST_ADDR    = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU snoop, responder read data and DMA bus signals of the OAM DMA.
interface oam_dma_if;
    import oam_dma_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rw;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_rw;
    logic [DATA_W-1:0] dma_data;
    logic              bus_own;
    logic              cpu_halt;
    logic              done;

    modport master (
        input  cpu_addr, cpu_rw, cpu_data, mem_data,
        output dma_addr, dma_rw, dma_data, bus_own, cpu_halt, done
    );

    modport slave (
        output cpu_addr, cpu_rw, cpu_data, mem_data,
        input  dma_addr, dma_rw, dma_data, bus_own, cpu_halt, done
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: on a CPU write to the trigger register, halts the CPU and copies
// one 256-byte page to the fixed OAM data port, one read/write pair per byte.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
    parameter logic [ADDR_W-1:0] DEST_ADDR    = DEF_DEST_ADDR
) (
    input  logic          clock,
    input  logic          nreset,
    oam_dma_if.master     bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

    state_t            state,    state_nxt;
    logic [IDX_W-1:0]  idx,      idx_nxt;
    logic [DATA_W-1:0] page,     page_nxt;
    logic              parity;
    logic [ADDR_W-1:0] addr_q,   addr_nxt;
    logic              rw_q,     rw_nxt;
    logic [DATA_W-1:0] data_q,   data_nxt;
    logic              own_q,    own_nxt;
    logic              halt_q,   halt_nxt;
    logic              done_q,   done_nxt;
    logic [IDX_W-1:0]  idx_inc;
    logic              trigger;

    assign idx_inc = idx + IDX_W'(1);
    // Snooping is only live in IDLE, so a transfer cannot be restarted.
    assign trigger = (bus.cpu_rw == 1'b0) && (bus.cpu_addr == TRIGGER_ADDR);

    // State and registered outputs; parity runs free from reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            idx    <= '0;
            page   <= '0;
            parity <= 1'b0;
            addr_q <= '0;
            rw_q   <= 1'b1;
            data_q <= '0;
            own_q  <= 1'b0;
            halt_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            page   <= page_nxt;
            parity <= ~parity;
            addr_q <= addr_nxt;
            rw_q   <= rw_nxt;
            data_q <= data_nxt;
            own_q  <= own_nxt;
            halt_q <= halt_nxt;
            done_q <= done_nxt;
        end
    end

    // Next state and next output values; outputs are set on entry to each state.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        page_nxt  = page;
        addr_nxt  = addr_q;
        rw_nxt    = rw_q;
        data_nxt  = data_q;
        own_nxt   = own_q;
        halt_nxt  = halt_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    page_nxt  = bus.cpu_data;
                    idx_nxt   = '0;
                    own_nxt   = 1'b1;
                    halt_nxt  = 1'b1;
                    addr_nxt  = {bus.cpu_data, 8'h00};
                    rw_nxt    = 1'b1;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // A halt landing on a put cycle needs one extra dummy read.
                addr_nxt  = {page, idx};
                state_nxt = parity ? ALIGN : READ;
            end
            ALIGN: begin
                addr_nxt  = {page, idx};
                state_nxt = READ;
            end
            READ: begin
                // Read data for the address driven on entry to READ is valid now.
                data_nxt  = bus.mem_data;
                addr_nxt  = DEST_ADDR;
                rw_nxt    = 1'b0;
                state_nxt = WRITE;
            end
            WRITE: begin
                rw_nxt = 1'b1;
                if (idx == LAST_IDX) begin
                    addr_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx_inc;
                    addr_nxt  = {page, idx_inc};
                    state_nxt = READ;
                end
            end
            DONE: begin
                own_nxt   = 1'b0;
                halt_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.dma_addr = addr_q;
    assign bus.dma_rw   = rw_q;
    assign bus.dma_data = data_q;
    assign bus.bus_own  = own_q;
    assign bus.cpu_halt = halt_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table, directed corner cases and
// randomized transfers checked against a page-copy reference model.
module tb_oam_dma;
    import oam_dma_pkg::*;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    oam_dma_if bus();

    oam_dma dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    logic [7:0] mem [0:65535];
    int unsigned n_edges;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        bit          starts;
    } vec_t;

    vec_t tbl [6];

    // Clock edges seen since reset release; the get/put phase is its parity.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) n_edges <= 0;
        else         n_edges <= n_edges + 1;
    end

    // Responder: registers read data on the falling edge from the muxed bus.
    always @(negedge clock) begin
        bus.mem_data <= mem[bus.bus_own ? bus.dma_addr : bus.cpu_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cpu_addr = 16'h0000;
        bus.cpu_rw   = 1'b1;
        bus.cpu_data = 8'h00;
    endtask

    task automatic check_idle(input string tag, input bit with_addr);
        check({tag, "_own"},  32'(bus.bus_own),  32'(0));
        check({tag, "_halt"}, 32'(bus.cpu_halt), 32'(0));
        check({tag, "_rw"},   32'(bus.dma_rw),   32'(1));
        check({tag, "_done"}, 32'(bus.done),     32'(0));
        if (with_addr) check({tag, "_addr"}, 32'(bus.dma_addr), 32'(0));
    endtask

    // Align is expected when the halt cycle falls on a put cycle.
    function automatic bit align_if_triggered_now();
        return 1'((n_edges + 1) % 2);
    endfunction

    // Entered while the halt cycle is being sampled; follows the transfer to its end.
    task automatic finish_transfer(input logic [7:0] page, input bit exp_align, input bit hold);
        int own = 0;
        int beats = 0;
        int reads = 0;
        int dones = 0;
        int exp_own = 514 + int'(exp_align);
        bit timeout = 1'b1;
        logic [15:0] last_rd = 16'hxxxx;
        logic [15:0] exp_rd;

        check("halt_addr", 32'(bus.dma_addr), 32'({page, 8'h00}));
        check("halt_rw",   32'(bus.dma_rw),   32'(1));
        check("halt_own",  32'(bus.bus_own),  32'(1));
        if (hold) begin
            bus.cpu_addr = DEF_TRIGGER_ADDR;
            bus.cpu_rw   = 1'b0;
            bus.cpu_data = ~page;
        end
        for (int c = 0; c < 700; c++) begin
            if (!bus.bus_own) begin
                timeout = 1'b0;
                break;
            end
            own++;
            check("cpu_halt", 32'(bus.cpu_halt), 32'(1));
            if (bus.dma_rw == 1'b0) begin
                exp_rd = {page, beats[7:0]};
                check("wr_addr", 32'(bus.dma_addr), 32'(DEF_DEST_ADDR));
                check("wr_data", 32'(bus.dma_data), 32'(mem[exp_rd]));
                check("rd_before_wr", 32'(last_rd), 32'(exp_rd));
                beats++;
            end else if (!bus.done) begin
                check("rd_page", 32'(bus.dma_addr[15:8]), 32'(page));
                last_rd = bus.dma_addr;
                reads++;
            end
            if (bus.done) begin
                dones++;
                check("done_last_cycle", 32'(own), 32'(exp_own));
            end
            step();
        end
        check("xfer_timeout", 32'(timeout), 32'(0));
        check("own_cycles", 32'(own), 32'(exp_own));
        check("beats", 32'(beats), 32'(256));
        check("reads", 32'(reads), 32'(257 + int'(exp_align)));
        check("done_pulses", 32'(dones), 32'(1));
        cpu_idle();
        for (int c = 0; c < 4; c++) begin
            check_idle("post", 1'b0);
            step();
        end
    endtask

    task automatic do_transfer(input logic [7:0] page, input bit want_align, input bit hold);
        if (align_if_triggered_now() != want_align) step();
        bus.cpu_addr = DEF_TRIGGER_ADDR;
        bus.cpu_rw   = 1'b0;
        bus.cpu_data = page;
        step();
        cpu_idle();
        finish_transfer(page, want_align, hold);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        tbl[0] = '{16'h4014, 1'b1, 8'h02, 1'b0};
        tbl[1] = '{16'h4015, 1'b0, 8'h02, 1'b0};
        tbl[2] = '{16'hC014, 1'b0, 8'h02, 1'b0};
        tbl[3] = '{16'h0014, 1'b0, 8'h02, 1'b0};
        tbl[4] = '{16'h4014, 1'b0, 8'h07, 1'b1};
        tbl[5] = '{16'h4004, 1'b0, 8'h07, 1'b0};

        cpu_idle();
        #12;
        check_idle("reset", 1'b1);
        @(negedge clock);
        nreset = 1'b1;
        step();
        check_idle("after_reset", 1'b1);

        // Vector table: only a CPU write to the trigger address starts a transfer.
        for (int v = 0; v < 6; v++) begin
            bit al;
            al = align_if_triggered_now();
            bus.cpu_addr = tbl[v].addr;
            bus.cpu_rw   = tbl[v].rw;
            bus.cpu_data = tbl[v].data;
            step();
            cpu_idle();
            check("tbl_own",  32'(bus.bus_own),  32'(tbl[v].starts));
            check("tbl_halt", 32'(bus.cpu_halt), 32'(tbl[v].starts));
            if (tbl[v].starts) finish_transfer(tbl[v].data, al, 1'b0);
            else check("tbl_rw", 32'(bus.dma_rw), 32'(1));
        end

        // Even and odd phase on page $02; odd run also holds a trigger throughout.
        do_transfer(8'h02, 1'b0, 1'b0);
        do_transfer(8'h02, 1'b1, 1'b1);
        do_transfer(8'hFF, 1'($urandom % 2), 1'b0);

        // Reset in the middle of a transfer.
        begin
            int beats = 0;
            bit reached = 1'b0;
            bus.cpu_addr = DEF_TRIGGER_ADDR;
            bus.cpu_rw   = 1'b0;
            bus.cpu_data = 8'h05;
            step();
            cpu_idle();
            for (int c = 0; c < 400; c++) begin
                if (bus.bus_own && !bus.dma_rw) beats++;
                if (beats == 100) begin
                    reached = 1'b1;
                    break;
                end
                step();
            end
            check("reset_mid_reached", 32'(reached), 32'(1));
            #2;
            nreset = 1'b0;
            #1;
            check_idle("reset_mid", 1'b1);
            repeat (3) @(posedge clock);
            @(negedge clock);
            nreset = 1'b1;
            for (int c = 0; c < 6; c++) begin
                step();
                check_idle("reset_quiet", 1'b1);
            end
            do_transfer(8'h03, 1'($urandom % 2), 1'b0);
        end

        // Random CPU traffic: the model starts a copy only on a trigger write.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            logic        rw;
            logic [7:0]  d;
            bit          starts;
            bit          al;
            case ($urandom % 4)
                0:       a = DEF_TRIGGER_ADDR;
                1:       a = 16'h4015;
                default: a = 16'($urandom);
            endcase
            rw = (($urandom % 8) != 0);
            d  = 8'($urandom);
            starts = (rw == 1'b0) && (a == DEF_TRIGGER_ADDR);
            al = align_if_triggered_now();
            bus.cpu_addr = a;
            bus.cpu_rw   = rw;
            bus.cpu_data = d;
            step();
            cpu_idle();
            check("rnd_own", 32'(bus.bus_own), 32'(starts));
            if (starts) finish_transfer(d, al, 1'($urandom % 2));
        end

        for (int t = 0; t < 2; t++)
            do_transfer(8'($urandom), 1'($urandom % 2), 1'($urandom % 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
